mac_result_drain: RTL
=====================

# mac_result_drain

Downstream stage of the MAC top block. Accepts a completed result matrix over the block-to-host valid/ready handshake, pulses the result-memory read enable, and captures the flattened C matrix into a local buffer. It then streams the M*N elements out one per transfer on a valid/ready output port, with optional signed saturation to a narrower output width. It is the only consumer of the MAC top's result bus.

## Interface

Parameters:
- param_M, 4, result rows
- param_N, 4, result columns
- DATA_WIDTH_FINAL, 16, width of one result element on the input bus
- OUT_WIDTH, 8, width of one streamed element; must be <= DATA_WIDTH_FINAL
- SATURATE, 1, 1 = signed saturation to OUT_WIDTH; 0 = keep the low OUT_WIDTH bits
- READ_LAT, 1, cycles from c_re_out to valid c_data_in (1..3)

Ports:
- clk  in  1  clock; one clock domain, all logic on the rising edge
- rstn  in  1  asynchronous, active-low reset
- blk_val_in  in  1  result available (the MAC top's block2host_val)
- blk_rdy_out  out  1  drain can accept a result (to the MAC top's block2host_rdy)
- c_re_out  out  1  result-memory read enable (to the MAC top's c_re_ext)
- c_data_in  in  param_M*param_N*DATA_WIDTH_FINAL  flattened result; element i is at bits [i*DATA_WIDTH_FINAL +: DATA_WIDTH_FINAL]
- out_data  out  OUT_WIDTH  streamed element
- out_val  out  1  out_data valid
- out_rdy  in  1  consumer ready
- out_last  out  1  high with element M*N-1
- out_idx  out  $clog2(M*N)  index of the current element
- out_sat  out  1  current element was clipped
- busy  out  1  state is not IDLE

## Operation

- States: IDLE, READ, STREAM (a 2-bit enum).
- IDLE:
  - blk_rdy_out = 1.
  - The handshake fires when blk_val_in && blk_rdy_out.
  - c_re_out = blk_val_in, combinationally, during IDLE only.
  - When the handshake fires, go to READ and load the latency counter with READ_LAT-1.
- READ:
  - blk_rdy_out = 0 and c_re_out = 0.
  - Count down. On the cycle the count reaches 0, register all of c_data_in into the buffer, clear the index, and go to STREAM.
- STREAM:
  - out_val = 1.
  - out_data and out_sat are derived from buffer element out_idx.
  - out_last = (out_idx == M*N-1).
  - On out_val && out_rdy:
    - If out_last is high, go to IDLE.
    - Otherwise increment out_idx.
- Saturation, with SATURATE=1 and the element taken as signed:
  - above 2^(OUT_WIDTH-1)-1 -> output that maximum, out_sat=1
  - below -2^(OUT_WIDTH-1) -> output that minimum, out_sat=1
  - otherwise -> low OUT_WIDTH bits, out_sat=0
- With SATURATE=0: output the low OUT_WIDTH bits and hold out_sat at 0.
- When OUT_WIDTH == DATA_WIDTH_FINAL, the element passes through unchanged and out_sat is 0.
- blk_val_in outside IDLE is ignored. No request is latched for later.
- Reset is asynchronous at any point, including mid-READ or mid-STREAM. It discards the buffer contents and any partial stream. No out_last is produced for the aborted matrix.

## Timing

- Reset values:
  - state = IDLE
  - out_val, out_last, out_sat, c_re_out, busy = 0
  - out_idx = 0; out_data = 0
  - blk_rdy_out = 1 (IDLE)
- Handshake at cycle T:
  - c_re_out is high in cycle T only.
  - The buffer is captured at the end of cycle T+READ_LAT.
  - First out_val is in cycle T+READ_LAT+1.
- Throughput: one element per cycle while out_rdy is held. A full matrix streams in M*N cycles.
- Stall: while out_val && !out_rdy, out_data, out_idx, out_last and out_sat are held stable.
- After the last transfer in cycle L:
  - state is IDLE and blk_rdy_out = 1 in cycle L+1.
  - The earliest next handshake is in L+1. There is no same-cycle turnaround.
- out_data and out_sat are driven from registered state and the buffer only. out_rdy has no combinational path to any output.

## Structure

- Package mac_pkg:
  - the state_t enum {IDLE, READ, STREAM}
  - a localparam-style function for the element count M*N
  - the index-width helper ($clog2)
- Sub-module mac_sat_trunc: combinational, parameterised by IN_W, OUT_W and SATURATE. It maps one element to OUT_W bits and a sat flag, and is instantiated once at the buffer read port.
- The top of this block contains the FSM, the latency counter, the M*N-entry buffer and the index counter.

## Test plan

- Reset and idle: assert rstn=0 mid-stream at element 5 -> all outputs return to their reset values asynchronously. After release: blk_rdy_out=1, no out_val.
- Basic drain, defaults:
  - Stimulus: pulse blk_val_in for 1 cycle with element i = i.
  - Response: c_re_out high for 1 cycle; out_data 0..15 on consecutive cycles with out_rdy=1; out_last only on idx 15; first out_val 2 cycles after the handshake.
- Saturation, SATURATE=1, elements 16'h0190 (400), 16'hFE70 (-400) and 16'h0040 -> outputs 8'h7F (sat=1), 8'h80 (sat=1) and 8'h40 (sat=0).
- Truncation, SATURATE=0, element 16'h0190 -> 8'h90 with sat=0.
- Backpressure: toggle out_rdy randomly -> data, index and last are stable during stalls, and all 16 elements arrive in order exactly once.
- Back-to-back results:
  - Stimulus: blk_val_in held high throughout, with READ_LAT=3.
  - Response: the second handshake occurs only in the cycle after the first out_last transfer; blk_val_in during STREAM causes no c_re_out.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the MAC result drain.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    STREAM = 2'd2
  } state_t;

  function automatic int elem_cnt(input int m, input int n);
    return m * n;
  endfunction

  function automatic int idx_w(input int cnt);
    return (cnt > 1) ? $clog2(cnt) : 1;
  endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// Result-in handshake and element-out stream of the drain.
interface mac_result_drain_if
  import mac_pkg::*;
#(
  parameter int M  = 4,
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int OW = 8
);

  localparam int CNT = elem_cnt(M, N);
  localparam int IW  = idx_w(CNT);

  logic              blk_val_in;
  logic              blk_rdy_out;
  logic              c_re_out;
  logic [CNT*DW-1:0] c_data_in;
  logic [OW-1:0]     out_data;
  logic              out_val;
  logic              out_rdy;
  logic              out_last;
  logic [IW-1:0]     out_idx;
  logic              out_sat;
  logic              busy;

  modport master (
    output blk_val_in,
    output c_data_in,
    output out_rdy,
    input  blk_rdy_out,
    input  c_re_out,
    input  out_data,
    input  out_val,
    input  out_last,
    input  out_idx,
    input  out_sat,
    input  busy
  );

  modport slave (
    input  blk_val_in,
    input  c_data_in,
    input  out_rdy,
    output blk_rdy_out,
    output c_re_out,
    output out_data,
    output out_val,
    output out_last,
    output out_idx,
    output out_sat,
    output busy
  );

endinterface

// File: rtl/mac_sat_trunc.sv
// Maps one result element to the output width, saturating or truncating.
module mac_sat_trunc #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);

  generate
    if (SATURATE != 0 && OUT_W < IN_W) begin : g_sat
      logic [IN_W-OUT_W:0] top;
      logic                ovf;
      logic [OUT_W-1:0]    pos_max;
      logic [OUT_W-1:0]    neg_min;

      // Fits iff every bit from the output sign bit upward agrees.
      assign top     = din[IN_W-1:OUT_W-1];
      assign ovf     = !((&top) || !(|top));
      assign pos_max = {1'b0, {(OUT_W-1){1'b1}}};
      assign neg_min = {1'b1, {(OUT_W-1){1'b0}}};

      always_comb begin
        dout = din[OUT_W-1:0];
        sat  = 1'b0;
        if (ovf) begin
          dout = din[IN_W-1] ? neg_min : pos_max;
          sat  = 1'b1;
        end
      end
    end else begin : g_trunc
      logic unused_din;

      assign unused_din = ^din;
      assign dout       = din[OUT_W-1:0];
      assign sat        = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mac_result_drain.sv
// Captures a finished C matrix and streams it out one element per transfer.
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int param_M          = 4,
  parameter int param_N          = 4,
  parameter int DATA_WIDTH_FINAL = 16,
  parameter int OUT_WIDTH        = 8,
  parameter int SATURATE         = 1,
  parameter int READ_LAT         = 1
) (
  input logic               clk,
  input logic               rstn,
  mac_result_drain_if.slave bus
);

  localparam int CNT = elem_cnt(param_M, param_N);
  localparam int IW  = idx_w(CNT);
  localparam int DW  = DATA_WIDTH_FINAL;
  localparam int LW  = 2;

  localparam logic [IW-1:0] LAST_IDX = IW'(CNT - 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(READ_LAT - 1);

  state_t        state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] buf_q [CNT];
  logic [DW-1:0] buf_d [CNT];

  logic             is_idle;
  logic             is_read;
  logic             is_strm;
  logic             hs;
  logic             last;
  logic             cap;
  logic [DW-1:0]    elem;
  logic [OUT_WIDTH-1:0] st_data;
  logic             st_sat;

  assign is_idle = (state_q == IDLE);
  assign is_read = (state_q == READ);
  assign is_strm = (state_q == STREAM);
  assign hs      = is_idle && bus.blk_val_in;
  assign last    = is_strm && (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    idx_d   = idx_q;
    cap     = 1'b0;
    unique case (1'b1)
      is_idle: begin
        if (hs) begin
          state_d = READ;
          lat_d   = LAT_INIT;
        end
      end
      is_read: begin
        if (lat_q == '0) begin
          cap     = 1'b1;
          idx_d   = '0;
          state_d = STREAM;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      is_strm: begin
        if (bus.out_rdy) begin
          if (last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < CNT; i++) begin
      buf_d[i] = cap ? bus.c_data_in[i*DW +: DW] : buf_q[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      lat_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < CNT; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  assign elem = buf_q[idx_q];

  mac_sat_trunc #(
    .IN_W     (DW),
    .OUT_W    (OUT_WIDTH),
    .SATURATE (SATURATE)
  ) u_sat (
    .din  (elem),
    .dout (st_data),
    .sat  (st_sat)
  );

  // Outputs are quiet outside STREAM so stale buffer data never leaks.
  assign bus.blk_rdy_out = is_idle;
  assign bus.c_re_out    = hs;
  assign bus.out_val     = is_strm;
  assign bus.out_last    = last;
  assign bus.out_idx     = idx_q;
  assign bus.out_data    = is_strm ? st_data : '0;
  assign bus.out_sat     = is_strm && st_sat;
  assign bus.busy        = !is_idle;

endmodule
